// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES types and tables: state array, byte vector view, FSM states, S-boxes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t is the [i][j] byte array, byte k = 4*i + j.
//           byte_vec_t is the same 128 bits viewed as 16 flat bytes.
//           SBOX and INV_SBOX are the FIPS-197 forward and inverse S-boxes.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    // Flat view of state_t: byte k occupies the same bits as element [k/4][k%4].
    typedef logic [15:0][7:0] byte_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Handshake bundle for the SubBytes engine: input block channel, output block channel, control.
// Latency: n/a (wiring only).
// Backpressure: in_ready_o stalls the producer; out_ready_i stalls the engine in DONE.
// Signals: in_valid_i/in_ready_o/in_i/mode_i (input channel), abort_i (control),
//          out_valid_o/out_ready_i/out_o (output channel), busy_o (status).
// Modports: master = block producer/consumer side, slave = engine side.
interface sub_bytes_engine_if;
    import aes_pkg::*;

    logic   in_valid_i;
    logic   in_ready_o;
    state_t in_i;
    logic   mode_i;
    logic   abort_i;
    logic   out_valid_o;
    logic   out_ready_i;
    state_t out_o;
    logic   busy_o;

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_i,
        output mode_i,
        output abort_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_o,
        input  busy_o
    );

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_i,
        input  mode_i,
        input  abort_i,
        output out_valid_o,
        input  out_ready_i,
        output out_o,
        output busy_o
    );

endinterface

// File: rtl/sub_bytes_engine_sbox_lane.sv
// One combinational S-box lane: forward or inverse byte substitution.
// Latency: 0 cycles (pure combinational lookup).
// Backpressure: none; the owner decides when the result is used.
// Ports: din (byte in), mode (0 forward, 1 inverse), dout (substituted byte).
module sbox_lane
    import aes_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [7:0] din,
    input  logic       mode,
    output logic [7:0] dout
);

    generate
        if (INV_EN != 0) begin : g_inv
            assign dout = mode ? INV_SBOX[din] : SBOX[din];
        end else begin : g_fwd
            // Forward-only build: the mode bit is deliberately ignored.
            logic unused_mode;
            assign unused_mode = mode;
            assign dout        = SBOX[din];
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes engine processing LANES bytes per cycle over a 16-byte state.
// Latency: out_valid_o rises 16/LANES cycles after the accepting edge.
// Backpressure: holds the finished block in DONE until out_ready_i; accepts a new block only in IDLE or when DONE drains.
// Ports: clk_i (clock), rst_i (async active-low reset),
//        bus (slave side of sub_bytes_engine_if: block in/out handshakes, mode, abort, busy).
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sub_bytes_engine_if.slave   bus
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    fsm_t            state_q;
    fsm_t            state_d;
    logic [CW-1:0]   cnt_q;
    byte_vec_t       in_buf_q;
    logic            mode_q;
    byte_vec_t       out_q;

    logic            abort_act;
    logic            accept;
    logic            last_beat;

    logic [3:0]      lane_idx [LANES];
    logic [7:0]      lane_din [LANES];
    logic [7:0]      lane_dout[LANES];

    // Abort only matters once a block is in flight; in IDLE it is ignored.
    assign abort_act       = bus.abort_i && (state_q != IDLE);
    assign bus.in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready_i);
    // Abort wins over a same-cycle acceptance, so the offered block is not taken.
    assign accept          = bus.in_valid_i && bus.in_ready_o && !abort_act;
    assign last_beat       = (cnt_q == CW'(N - 1));

    assign bus.out_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q == RUN);
    assign bus.out_o       = out_q;

    // Lane m works on byte cnt*LANES + m; a cnt-indexed mux picks it from the buffer.
    generate
        for (genvar m = 0; m < LANES; m++) begin : g_lane
            assign lane_idx[m] = 4'(int'(cnt_q) * LANES + m);
            assign lane_din[m] = in_buf_q[lane_idx[m]];

            sbox_lane #(
                .INV_EN (INV_EN)
            ) u_lane (
                .din  (lane_din[m]),
                .mode (mode_q),
                .dout (lane_dout[m])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_act) begin
                    state_d = IDLE;
                end else if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort_act) begin
                    state_d = IDLE;
                end else if (bus.out_ready_i) begin
                    // Draining and refilling in the same cycle avoids an IDLE bubble.
                    state_d = accept ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            in_buf_q <= '0;
            mode_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                in_buf_q <= bus.in_i;
                mode_q   <= bus.mode_i;
                cnt_q    <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Only the bytes of the current beat change; the rest keep their old contents.
            if (state_q == RUN) begin
                for (int m = 0; m < LANES; m++) begin
                    out_q[lane_idx[m]] <= lane_dout[m];
                end
            end
        end
    end

endmodule
